// File: rtl/latch_byte_serializer.sv
// latch_byte_serializer: captures a latched parallel word on a load handshake and
// shifts it out one bit per accepted transfer, optionally followed by an even-parity bit.
`default_nettype none

module latch_byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  output logic             o_sout,
  output logic             o_sout_valid,
  input  logic             i_sout_ready,
  output logic             o_last,
  output logic             o_busy,
  output logic             o_done
);

  localparam int FRAME = WIDTH + int'(PARITY_EN);
  localparam int CW    = $clog2(FRAME + 1);
  localparam logic [CW-1:0] c_DATA_END = CW'(WIDTH);
  localparam logic [CW-1:0] c_LAST_CNT = CW'(FRAME - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_shift;
  logic [CW-1:0]     r_cnt;
  logic              r_par;
  logic              r_load_ready;
  logic              r_sout;
  logic              r_sout_valid;
  logic              r_last;
  logic              r_busy;
  logic              r_done;

  logic [WIDTH-1:0]  w_shift_nxt;
  logic              w_first_bit;
  logic              w_next_data;
  logic [CW-1:0]     w_cnt_nxt;
  logic              w_sout_nxt;

  // The word is rotated rather than shifted so the outgoing bit always sits at a fixed end.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shift_nxt = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
      assign w_first_bit = i_d[WIDTH-1];
      assign w_next_data = r_shift[WIDTH-2];
    end else begin : g_lsb
      assign w_shift_nxt = {r_shift[0], r_shift[WIDTH-1:1]};
      assign w_first_bit = i_d[0];
      assign w_next_data = r_shift[1];
    end
  endgenerate

  assign w_cnt_nxt  = r_cnt + CW'(1);
  assign w_sout_nxt = (w_cnt_nxt < c_DATA_END) ? w_next_data : r_par;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_par        <= 1'b0;
      r_load_ready <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_load_ready <= 1'b1;
          r_done       <= 1'b0;
          if (i_load_valid && r_load_ready) begin
            r_shift      <= i_d;
            r_par        <= ^i_d;
            r_cnt        <= '0;
            r_state      <= S_SHIFT;
            r_load_ready <= 1'b0;
            r_sout       <= w_first_bit;
            r_sout_valid <= 1'b1;
            r_last       <= 1'b0;
            r_busy       <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (i_sout_ready) begin
            if (r_last) begin
              r_state      <= S_DONE;
              r_sout       <= 1'b0;
              r_sout_valid <= 1'b0;
              r_last       <= 1'b0;
              r_done       <= 1'b1;
            end else begin
              r_cnt   <= w_cnt_nxt;
              r_shift <= w_shift_nxt;
              r_sout  <= w_sout_nxt;
              r_last  <= (w_cnt_nxt == c_LAST_CNT);
            end
          end
        end
        S_DONE: begin
          r_state      <= S_IDLE;
          r_done       <= 1'b0;
          r_busy       <= 1'b0;
          r_load_ready <= 1'b1;
        end
        default: begin
          r_state      <= S_IDLE;
          r_load_ready <= 1'b0;
          r_sout_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  // Outputs are forced low for as long as reset is held, not only after the reset edge.
  assign o_load_ready = r_load_ready & rst;
  assign o_sout       = r_sout & rst;
  assign o_sout_valid = r_sout_valid & rst;
  assign o_last       = r_last & rst;
  assign o_busy       = r_busy & rst;
  assign o_done       = r_done & rst;

endmodule

`default_nettype wire

// File: tb/tb_latch_byte_serializer.sv
// Testbench for latch_byte_serializer: three configurations checked against a frame-level model.
`default_nettype none

module tb_latch_byte_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] d  [3];
  logic       lv [3];
  logic       sr [3];
  logic       lr [3];
  logic       so [3];
  logic       sv [3];
  logic       la [3];
  logic       bu [3];
  logic       dn [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  latch_byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b1)) u_def (
    .clk(clk), .rst(rst), .i_d(d[0]), .i_load_valid(lv[0]), .o_load_ready(lr[0]),
    .o_sout(so[0]), .o_sout_valid(sv[0]), .i_sout_ready(sr[0]), .o_last(la[0]),
    .o_busy(bu[0]), .o_done(dn[0]));

  latch_byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .PARITY_EN(1'b1)) u_msb (
    .clk(clk), .rst(rst), .i_d(d[1]), .i_load_valid(lv[1]), .o_load_ready(lr[1]),
    .o_sout(so[1]), .o_sout_valid(sv[1]), .i_sout_ready(sr[1]), .o_last(la[1]),
    .o_busy(bu[1]), .o_done(dn[1]));

  latch_byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .PARITY_EN(1'b0)) u_nop (
    .clk(clk), .rst(rst), .i_d(d[2]), .i_load_valid(lv[2]), .o_load_ready(lr[2]),
    .o_sout(so[2]), .o_sout_valid(sv[2]), .i_sout_ready(sr[2]), .o_last(la[2]),
    .o_busy(bu[2]), .o_done(dn[2]));

  // Reference: bit idx of the frame for word v; index 8 is the even-parity bit.
  function automatic logic frame_bit(input logic [7:0] v, input bit msb, input int idx);
    if (idx < 8) return msb ? v[7 - idx] : v[idx];
    return logic'($countones(v) % 2);
  endfunction

  function automatic int frame_len(input int k);
    return (k == 2) ? 8 : 9;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lv[k] = 1'b0; sr[k] = 1'b1; d[k] = 8'h00;
    end
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({lr[k], so[k], sv[k], la[k], bu[k], dn[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: got %b expected 000000", k,
                 {lr[k], so[k], sv[k], la[k], bu[k], dn[k]});
      end
    end
    rst = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (lr[k] !== 1'b1 || bu[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release dut%0d: load_ready=%b busy=%b expected 1/0", k, lr[k], bu[k]);
      end
    end
  endtask

  task automatic test_lsb_parity();
    d[0] = 8'hA5; lv[0] = 1'b1; sr[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (sv[0] !== 1'b1 || so[0] !== frame_bit(8'hA5, 1'b0, i) || la[0] !== (i == 8) || dn[0] !== 1'b0) begin
        errors++;
        $display("FAIL lsb_bit%0d: valid=%b sout=%b last=%b done=%b expected 1/%b/%b/0", i,
                 sv[0], so[0], la[0], dn[0], frame_bit(8'hA5, 1'b0, i), (i == 8));
      end
      tick();
    end
    checks++;
    if (dn[0] !== 1'b1 || sv[0] !== 1'b0 || bu[0] !== 1'b1 || lr[0] !== 1'b0) begin
      errors++;
      $display("FAIL lsb_done: done=%b valid=%b busy=%b ready=%b expected 1/0/1/0", dn[0], sv[0], bu[0], lr[0]);
    end
    tick();
    checks++;
    if (dn[0] !== 1'b0 || lr[0] !== 1'b1 || bu[0] !== 1'b0) begin
      errors++;
      $display("FAIL lsb_idle: done=%b ready=%b busy=%b expected 0/1/0", dn[0], lr[0], bu[0]);
    end
  endtask

  task automatic test_msb_first();
    d[1] = 8'h07; lv[1] = 1'b1; sr[1] = 1'b1;
    tick();
    lv[1] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (sv[1] !== 1'b1 || so[1] !== frame_bit(8'h07, 1'b1, i) || la[1] !== (i == 8)) begin
        errors++;
        $display("FAIL msb_bit%0d: valid=%b sout=%b last=%b expected 1/%b/%b", i,
                 sv[1], so[1], la[1], frame_bit(8'h07, 1'b1, i), (i == 8));
      end
      tick();
    end
    checks++;
    if (dn[1] !== 1'b1) begin
      errors++;
      $display("FAIL msb_done: got %b expected 1", dn[1]);
    end
    tick();
  endtask

  task automatic test_stall();
    int cyc;
    d[2] = 8'hFF; lv[2] = 1'b1; sr[2] = 1'b1;
    tick();
    lv[2] = 1'b0;
    cyc = 1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        sr[2] = 1'b0;
        for (int s = 0; s < 3; s++) begin
          checks++;
          if (sv[2] !== 1'b1 || so[2] !== 1'b1 || la[2] !== 1'b0 || dn[2] !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold%0d: valid=%b sout=%b last=%b done=%b expected 1/1/0/0", s,
                     sv[2], so[2], la[2], dn[2]);
          end
          tick(); cyc++;
        end
        sr[2] = 1'b1;
      end
      checks++;
      if (sv[2] !== 1'b1 || so[2] !== frame_bit(8'hFF, 1'b0, i) || la[2] !== (i == 7)) begin
        errors++;
        $display("FAIL stall_bit%0d: valid=%b sout=%b last=%b expected 1/1/%b", i, sv[2], so[2], la[2], (i == 7));
      end
      tick(); cyc++;
    end
    checks++;
    if (dn[2] !== 1'b1 || cyc != 8 + 1 + 3) begin
      errors++;
      $display("FAIL stall_done: done=%b at cycle %0d expected 1 at cycle 12", dn[2], cyc);
    end
    tick();
  endtask

  task automatic test_mid_frame();
    logic [7:0] val;
    val = 8'($urandom);
    d[0] = val; lv[0] = 1'b1; sr[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (so[0] !== frame_bit(val, 1'b0, i) || lr[0] !== 1'b0) begin
        errors++;
        $display("FAIL midframe_bit%0d: sout=%b ready=%b expected %b/0", i, so[0], lr[0], frame_bit(val, 1'b0, i));
      end
      if (i == 0) begin lv[0] = 1'b1; d[0] = 8'h00; end
      if (i == 3) d[0] = 8'h3C;
      tick();
    end
    checks++;
    if (dn[0] !== 1'b1 || lr[0] !== 1'b0) begin
      errors++;
      $display("FAIL midframe_done: done=%b ready=%b expected 1/0", dn[0], lr[0]);
    end
    lv[0] = 1'b0;
    tick();
    checks++;
    if (lr[0] !== 1'b1) begin
      errors++;
      $display("FAIL midframe_ready: got %b expected 1", lr[0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    d[0] = 8'($urandom); lv[0] = 1'b1; sr[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({lr[0], so[0], sv[0], la[0], bu[0], dn[0]} !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_held: got %b expected 000000", {lr[0], so[0], sv[0], la[0], bu[0], dn[0]});
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (lr[0] !== 1'b1 || dn[0] !== 1'b0 || sv[0] !== 1'b0 || bu[0] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: ready=%b done=%b valid=%b busy=%b expected 1/0/0/0", lr[0], dn[0], sv[0], bu[0]);
    end
    d[0] = 8'h81; lv[0] = 1'b1;
    tick();
    lv[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++;
      if (sv[0] !== 1'b1 || so[0] !== frame_bit(8'h81, 1'b0, i) || la[0] !== (i == 8)) begin
        errors++;
        $display("FAIL rstmid_bit%0d: valid=%b sout=%b last=%b expected 1/%b/%b", i,
                 sv[0], so[0], la[0], frame_bit(8'h81, 1'b0, i), (i == 8));
      end
      tick();
    end
    checks++;
    if (dn[0] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_done: got %b expected 1", dn[0]);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = -1; second = -1;
    d[0] = 8'h12; lv[0] = 1'b1; sr[0] = 1'b1;
    for (int t = 0; t < 40 && second < 0; t++) begin
      if (lr[0] === 1'b1) begin
        if (first < 0) first = t;
        else second = t;
      end
      tick();
    end
    lv[0] = 1'b0;
    checks++;
    if (first < 0 || second < 0 || (second - first) != 11) begin
      errors++;
      $display("FAIL back_to_back: capture spacing %0d expected 11", second - first);
    end
    for (int t = 0; t < 11; t++) tick();
    checks++;
    if (lr[0] !== 1'b1) begin
      errors++;
      $display("FAIL back_to_back_drain: ready=%b expected 1", lr[0]);
    end
  endtask

  task automatic test_random(input int k);
    logic [7:0] val;
    int idx, guard, fl;
    bit msb, acc;
    fl  = frame_len(k);
    msb = (k == 1);
    for (int f = 0; f < 6; f++) begin
      val = 8'($urandom);
      d[k] = val; lv[k] = 1'b1; sr[k] = 1'b1;
      checks++;
      if (lr[k] !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_ready f%0d: got %b expected 1", k, f, lr[k]);
      end
      tick();
      lv[k] = 1'b0;
      idx = 0; guard = 0;
      while (idx < fl && guard < 100) begin
        checks++;
        if (sv[k] !== 1'b1 || so[k] !== frame_bit(val, msb, idx) || la[k] !== (idx == fl - 1)) begin
          errors++;
          $display("FAIL rand%0d_bit%0d f%0d: valid=%b sout=%b last=%b expected 1/%b/%b", k, idx, f,
                   sv[k], so[k], la[k], frame_bit(val, msb, idx), (idx == fl - 1));
        end
        d[k] = 8'($urandom);
        acc = ($urandom_range(0, 3) != 0);
        sr[k] = acc;
        tick();
        if (acc) idx++;
        guard++;
      end
      sr[k] = 1'b1;
      checks++;
      if (guard >= 100 || dn[k] !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_done f%0d: done=%b guard=%0d expected 1", k, f, dn[k], guard);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_lsb_parity();
    test_msb_first();
    test_stall();
    test_mid_frame();
    test_reset_mid_frame();
    test_back_to_back();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
